// File: rtl/uart_pkt_pkg.sv
// Shared constants and types for the UART packet parser: default SOF byte,
// parser state encoding and error-cause encoding.
package uart_pkt_pkg;

    localparam logic [7:0] PKT_SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHK,
        DRAIN
    } pkt_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CHK     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } pkt_err_t;

endpackage

// File: rtl/pkt_payload_ram.sv
// Payload buffer: one synchronous write port, one combinational read port so a
// byte can be presented in the same cycle its read index changes.
module pkt_payload_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_pkt_parser.sv
// Framing stage behind the UART receiver: SOF, LEN, payload, additive checksum.
// Define PKT_TIMEOUT_EN to build the inter-byte timeout (error code 3).
//
// state   | meaning
// HUNT    | discard bytes until SOF
// LEN     | next byte is payload length, range-checked
// PAYLOAD | store bytes into the buffer, accumulate checksum
// CHK     | compare checksum byte with accumulator
// DRAIN   | stream buffered payload out, rx bytes ignored
module uart_pkt_parser
    import uart_pkt_pkg::*;
#(
    parameter int unsigned MAX_LEN      = 64,
    parameter logic [7:0]  SOF          = PKT_SOF_DEFAULT,
    parameter int unsigned TIMEOUT_CLKS = 17380
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 1) begin : g_bad_param
        $error("uart_pkt_parser: MAX_LEN must be 1..255 and TIMEOUT_CLKS nonzero");
    end

    pkt_state_t state_q, state_d;
    pkt_err_t   err_code_q, err_code_d;
    logic [7:0] len_q, len_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] rd_q, rd_d;
    logic       pkt_err_q, pkt_err_d;
    logic       busy_q;
    logic       ram_we;
    logic [7:0] ram_rdata;
    logic       to_expire;

    pkt_payload_ram #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (idx_q[AW-1:0]),
        .wdata_i (rx_byte),
        .raddr_i (rd_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

`ifdef PKT_TIMEOUT_EN
    localparam int unsigned TW      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CLKS);

    logic [TW-1:0] to_cnt_q;
    logic          in_frame;

    assign in_frame  = state_q inside {LEN, PAYLOAD, CHK};
    assign to_expire = in_frame && !rx_valid && (to_cnt_q == '0);

    // Loaded when SOF is accepted so LEN is covered from its first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if ((state_q == HUNT) && (state_d == LEN)) begin
            to_cnt_q <= TO_LOAD;
        end else if (in_frame && rx_valid) begin
            to_cnt_q <= TO_LOAD;
        end else if (in_frame && (to_cnt_q != '0)) begin
            to_cnt_q <= to_cnt_q - 1'b1;
        end
    end
`else
    assign to_expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        rd_d       = rd_q;
        pkt_err_d  = 1'b0;
        err_code_d = err_code_q;
        ram_we     = 1'b0;
        case (state_q)
            HUNT: begin
                if (rx_valid && (rx_byte == SOF)) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    if ((rx_byte == 8'd0) || (rx_byte > MAX_LEN_B)) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = HUNT;
                    end else begin
                        len_d   = rx_byte;
                        acc_d   = rx_byte;
                        idx_d   = 8'd0;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    ram_we = 1'b1;
                    idx_d  = idx_q + 8'd1;
                    acc_d  = acc_q + rx_byte;
                    if ((idx_q + 8'd1) == len_q) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (rx_valid) begin
                    if (rx_byte == acc_q) begin
                        rd_d    = 8'd0;
                        state_d = DRAIN;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_CHK;
                        state_d    = HUNT;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (rd_q == (len_q - 8'd1)) begin
                        rd_d    = 8'd0;
                        state_d = HUNT;
                    end else begin
                        rd_d = rd_q + 8'd1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
        if (to_expire) begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = HUNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            len_q      <= 8'd0;
            idx_q      <= 8'd0;
            acc_q      <= 8'd0;
            rd_q       <= 8'd0;
            pkt_err_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            rd_q       <= rd_d;
            pkt_err_q  <= pkt_err_d;
            err_code_q <= err_code_d;
            busy_q     <= (state_d != HUNT);
        end
    end

    // Data is forced to zero outside DRAIN so stale buffer contents never leak.
    assign out_valid = (state_q == DRAIN);
    assign out_data  = out_valid ? ram_rdata : 8'h00;
    assign out_last  = out_valid && (rd_q == (len_q - 8'd1));
    assign pkt_err   = pkt_err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;

endmodule
